// File: rtl/elevator_call_scheduler_if.sv
// Bundle of call-panel, car-core and scheduler output signals for the
// elevator call scheduler. The panel/core side drives through master and
// the scheduler sits on slave.
interface elevator_call_scheduler_if #(
  parameter int NUM_FLOORS = 10
);
  logic                  call_valid;
  logic [3:0]            call_floor;
  logic [3:0]            car_floor;
  logic                  car_arrived;
  logic                  emer_stop;
  logic                  peak_hour;
  logic [3:0]            target_floor;
  logic                  target_valid;
  logic                  dir_up;
  logic                  dir_down;
  logic                  door_open_req;
  logic [NUM_FLOORS-1:0] pending;
  logic                  call_err;

  modport master (
    output call_valid, call_floor, car_floor, car_arrived, emer_stop, peak_hour,
    input  target_floor, target_valid, dir_up, dir_down, door_open_req, pending, call_err
  );

  modport slave (
    input  call_valid, call_floor, car_floor, car_arrived, emer_stop, peak_hour,
    output target_floor, target_valid, dir_up, dir_down, door_open_req, pending, call_err
  );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: captures floor calls into a pending bitmap and
// feeds the car core one target at a time in collective (SCAN) order, with
// a door dwell at each stop and lobby parking during peak hour.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no live target; wait for calls, or start a peak-hour park move
// SELECT   | one cycle: pick the next target from the pending bitmap
// DISPATCH | target_valid high, car travelling toward target_floor
// DWELL    | doors held open for DWELL_CYCLES, reloaded by a car-floor call
// HALT     | emergency stop: doors open, no target, calls still captured
module elevator_call_scheduler #(
  parameter int NUM_FLOORS   = 10,
  parameter int DWELL_CYCLES = 8,
  parameter int PARK_FLOOR   = 0
) (
  input logic clk,
  input logic reset,
  elevator_call_scheduler_if.slave bus
);

  localparam int                CNT_W      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [4:0]        NF5        = 5'(NUM_FLOORS);
  localparam logic [3:0]        PARK       = 4'(PARK_FLOOR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_DISPATCH,
    S_DWELL,
    S_HALT
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            target_q, target_d;
  logic                  tvalid_q, tvalid_d;
  logic                  up_q, up_d;
  logic                  dn_q, dn_d;
  logic                  door_q, door_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;

  logic                  call_ok;
  logic                  dwell_call;
  logic                  car_pend;
  logic                  above_found, below_found;
  logic [3:0]            above_floor, below_floor;
  logic [3:0]            pick;
  logic                  clr_en;
  logic [3:0]            clr_floor;
  logic [NUM_FLOORS-1:0] set_mask, clr_mask;

  assign call_ok    = bus.call_valid && ({1'b0, bus.call_floor} < NF5);
  // A call at the car's own floor while the doors are open just extends
  // the dwell; the passenger is already being served.
  assign dwell_call = call_ok && (state_q == S_DWELL) && (bus.call_floor == bus.car_floor);

  // Nearest pending floor above and below the car, and whether the car's own floor is pending.
  always_comb begin
    above_found = 1'b0;
    above_floor = 4'd0;
    below_found = 1'b0;
    below_floor = 4'd0;
    car_pend    = 1'b0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (4'(i) > bus.car_floor)) begin
        above_found = 1'b1;
        above_floor = 4'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (4'(i) < bus.car_floor)) begin
        below_found = 1'b1;
        below_floor = 4'(i);
      end
      if (pending_q[i] && (4'(i) == bus.car_floor)) begin
        car_pend = 1'b1;
      end
    end
  end

  // Next-state, target, direction and dwell-counter decisions.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    up_d      = up_q;
    dn_d      = dn_q;
    cnt_d     = cnt_q;
    clr_en    = 1'b0;
    clr_floor = target_q;
    pick      = target_q;
    err_d     = bus.call_valid && !call_ok;

    case (state_q)
      S_IDLE: begin
        if (pending_q != '0) begin
          state_d = S_SELECT;
        end else if (bus.peak_hour && (bus.car_floor != PARK)) begin
          target_d = PARK;
          up_d     = PARK > bus.car_floor;
          dn_d     = PARK < bus.car_floor;
          state_d  = S_DISPATCH;
        end else begin
          up_d = 1'b0;
          dn_d = 1'b0;
        end
      end

      S_SELECT: begin
        if (car_pend) begin
          pick = bus.car_floor;
        end else if (!dn_q) begin
          pick = above_found ? above_floor : below_floor;
        end else begin
          pick = below_found ? below_floor : above_floor;
        end
        if (!car_pend && !above_found && !below_found) begin
          state_d = S_IDLE;
        end else begin
          target_d = pick;
          up_d     = pick > bus.car_floor;
          dn_d     = pick < bus.car_floor;
          if (pick == bus.car_floor) begin
            // Serving the current floor directly; retire its bit now so the
            // next SELECT does not pick it again.
            clr_en    = 1'b1;
            clr_floor = pick;
            cnt_d     = DWELL_LOAD;
            state_d   = S_DWELL;
          end else begin
            state_d = S_DISPATCH;
          end
        end
      end

      S_DISPATCH: begin
        if (bus.car_arrived && (bus.car_floor == target_q)) begin
          clr_en    = 1'b1;
          clr_floor = target_q;
          cnt_d     = DWELL_LOAD;
          state_d   = S_DWELL;
        end else if (call_ok &&
                     ((up_q && (bus.call_floor > bus.car_floor) && (bus.call_floor < target_q)) ||
                      (dn_q && (bus.call_floor < bus.car_floor) && (bus.call_floor > target_q)))) begin
          target_d = bus.call_floor;
        end
      end

      S_DWELL: begin
        if (dwell_call) begin
          cnt_d = DWELL_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_HALT: begin
        if (!bus.emer_stop) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Emergency stop freezes everything except call capture.
    if (bus.emer_stop) begin
      state_d  = S_HALT;
      target_d = target_q;
      up_d     = up_q;
      dn_d     = dn_q;
      cnt_d    = cnt_q;
      clr_en   = 1'b0;
    end
  end

  // Pending bitmap update; a set on the same bit as a clear wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      set_mask[i] = call_ok && !dwell_call && (bus.call_floor == 4'(i));
      clr_mask[i] = clr_en && (clr_floor == 4'(i));
    end
    pending_d = (pending_q & ~clr_mask) | set_mask;
    tvalid_d  = (state_d == S_DISPATCH);
    door_d    = (state_d == S_DWELL) || (state_d == S_HALT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      target_q  <= 4'd0;
      tvalid_q  <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      door_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      tvalid_q  <= tvalid_d;
      up_q      <= up_d;
      dn_q      <= dn_d;
      door_q    <= door_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign bus.target_floor  = target_q;
  assign bus.target_valid  = tvalid_q;
  assign bus.dir_up        = up_q;
  assign bus.dir_down      = dn_q;
  assign bus.door_open_req = door_q;
  assign bus.pending       = pending_q;
  assign bus.call_err      = err_q;

endmodule
